// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register: one outstanding imem read at a time.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_ISSUE   | drive imem_req for the current pc
// S_WAIT    | read outstanding, waiting for imem_rvalid
// S_DELIVER | word presented with inst_valid=1, held while stalled
// S_DISCARD | redirected while a read was in flight; drop its response
// S_FAULT   | misaligned redirect seen (trap build only); frozen until rst

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    output logic        flush
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [2:0] {
        S_ISSUE,
        S_WAIT,
        S_DELIVER,
        S_DISCARD
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc_out;
    logic [31:0] w_pc_out_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_frozen;
    logic [31:0] w_redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_fault;
    logic        w_fault_nxt;
    logic        w_misalign;

    assign w_frozen   = (r_state == S_FAULT);
    assign w_misalign = (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc = redirect_pc;
`else
    assign w_frozen   = 1'b0;
    // Low bits are dropped so the PC can never become misaligned.
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_ISSUE;
            r_pc     <= RESET_PC;
            r_instr  <= 32'h0;
            r_pc_out <= 32'h0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
        end
    end

    assign fetch_fault = r_fault;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        w_valid_nxt  = r_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_fault_nxt  = r_fault;
`endif
        if (redirect && !w_frozen) begin
            w_valid_nxt = 1'b0;
            w_pc_nxt    = w_redir_pc;
            // A read still in flight must be swallowed before fetching again.
            case (r_state)
                S_WAIT, S_DISCARD: w_state_nxt = imem_rvalid ? S_ISSUE : S_DISCARD;
                default:           w_state_nxt = S_ISSUE;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misalign) begin
                w_state_nxt = S_FAULT;
                w_fault_nxt = 1'b1;
            end
`endif
        end else begin
            case (r_state)
                S_ISSUE: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_instr_nxt  = imem_rdata;
                        w_pc_out_nxt = r_pc;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (!stall) begin
                        w_valid_nxt = 1'b0;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        w_state_nxt = S_ISSUE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign imem_req    = !rst && (r_state == S_ISSUE) && !redirect;
    assign imem_addr   = rst ? 32'h0 : r_pc;
    assign flush       = redirect && !rst;
    assign instruction = r_instr;
    assign pc_out      = r_pc_out;
    assign inst_valid  = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus randomized traffic against a flag-based model.
// Works with or without FETCH_MISALIGN_TRAP_EN defined.

module tb_if_fetch_unit;

    localparam logic [31:0] XOR_K    = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_RST = 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_rvalid, inst_valid, flush;
    logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
    logic        req2, rvalid2, valid2, flush2;
    logic [31:0] addr2, rdata2, instr2, pcout2;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault, fault2;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc_out(pc_out), .inst_valid(inst_valid), .flush(flush)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    if_fetch_unit #(.RESET_PC(WRAP_RST)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .instruction(instr2), .pc_out(pcout2), .inst_valid(valid2), .flush(flush2)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_fault(fault2)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: what the fetch stage is holding, in plain flags.
    logic [31:0] m_pc, m_instr, m_pcout;
    bit          m_busy, m_drop, m_word, m_fault;

    // Memory responders.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_min, lat_max;
    bit          m2_pend;
    logic [31:0] m2_addr;

    logic [31:0] req_log[$];
    int          vld_log[$];
    logic [31:0] q2[$];

    bit          last_req, last_flush, last_valid, last_fault;
    logic [31:0] last_addr, last_instr, last_pcout;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0;
        m_busy = 0; m_drop = 0; m_word = 0; m_fault = 0;
    endtask

    task automatic do_cycle(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
        bit          exp_req, rv, o_req2;
        logic [31:0] rdat, o_addr2;
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? (mem_addr ^ XOR_K) : $urandom;
        rvalid2     = m2_pend;
        rdata2      = m2_addr ^ XOR_K;
        #1;
        exp_req = !r && !m_fault && !m_busy && !m_word && !rd;
        check_val("imem_req", 32'(imem_req), 32'(exp_req));
        if (r) check_val("imem_addr_rst", imem_addr, 32'h0);
        else if (exp_req) check_val("imem_addr", imem_addr, m_pc);
        check_val("flush", 32'(flush), 32'(rd && !r));
        check_val("inst_valid", 32'(inst_valid), 32'(m_word));
        check_val("instruction", instruction, m_instr);
        check_val("pc_out", pc_out, m_pcout);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        last_fault = fetch_fault;
`else
        last_fault = 1'b0;
`endif
        last_req = imem_req; last_addr = imem_addr; last_flush = flush;
        last_valid = inst_valid; last_instr = instruction; last_pcout = pc_out;
        if (imem_req) req_log.push_back(imem_addr);
        if (inst_valid) vld_log.push_back(cyc);
        if (req2) q2.push_back(addr2);
        rv = imem_rvalid; rdat = imem_rdata;
        o_req2 = req2; o_addr2 = addr2;
        @(posedge clk);
        if (r) begin
            mem_pend = 0;
        end else begin
            if (rv) mem_pend = 0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (last_req) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
                mem_addr = last_addr;
            end
        end
        m2_pend = !r && o_req2;
        m2_addr = o_addr2;
        if (r) begin
            model_reset();
        end else if (m_fault) begin
            // frozen until reset
        end else if (rd) begin
            m_word = 0;
            if (TRAP && rpc[1:0] != 2'b00) begin
                m_fault = 1;
            end else begin
                m_pc = {rpc[31:2], 2'b00};
                if (m_busy && !rv) m_drop = 1;
                else begin m_busy = 0; m_drop = 0; end
            end
        end else if (m_word) begin
            if (!s) begin m_word = 0; m_pc = m_pc + 32'd4; end
        end else if (m_busy) begin
            if (rv) begin
                m_busy = 0;
                if (m_drop) m_drop = 0;
                else begin m_word = 1; m_instr = rdat; m_pcout = m_pc; end
            end
        end else begin
            m_busy = 1;
        end
        cyc++;
    endtask

    initial begin
        bit found;
        int nreq, vseen;
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
        imem_rvalid = 0; imem_rdata = 0; rvalid2 = 0; rdata2 = 0;
        model_reset();
        mem_pend = 0; mem_cnt = 0; mem_addr = 0; m2_pend = 0; m2_addr = 0;
        lat_min = 1; lat_max = 1;
        repeat (2) @(posedge clk);
        do_cycle(1, 0, 0, 0);
        do_cycle(1, 0, 0, 0);
        req_log.delete(); vld_log.delete(); q2.delete();

        // Back-to-back fetches with single-cycle memory.
        repeat (8) do_cycle(0, 0, 0, 0);
        check_val("seq_len", 32'(req_log.size()), 32'd3);
        if (req_log.size() == 3) begin
            check_val("seq_addr0", req_log[0], 32'h0);
            check_val("seq_addr1", req_log[1], 32'h4);
            check_val("seq_addr2", req_log[2], 32'h8);
        end
        check_val("valid_count", 32'(vld_log.size()), 32'd2);
        if (vld_log.size() == 2) check_val("valid_spacing", 32'(vld_log[1] - vld_log[0]), 32'd3);
        check_val("wrap_len", 32'(q2.size() >= 2), 32'd1);
        if (q2.size() >= 2) begin
            check_val("wrap_addr0", q2[0], WRAP_RST);
            check_val("wrap_addr1", q2[1], 32'h0);
        end

        // Stall holds the word at pc 8.
        repeat (4) begin
            do_cycle(0, 1, 0, 0);
            check_val("stall_valid", 32'(last_valid), 32'd1);
            check_val("stall_pc_out", last_pcout, 32'h8);
            check_val("stall_instr", last_instr, 32'h8 ^ XOR_K);
            check_val("stall_no_req", 32'(last_req), 32'd0);
        end
        do_cycle(0, 0, 0, 0);
        lat_min = 3; lat_max = 3;
        do_cycle(0, 0, 0, 0);
        check_val("after_stall_req", 32'(last_req), 32'd1);
        check_val("after_stall_addr", last_addr, 32'hC);

        // Redirect while the read is outstanding; its late data must be dropped.
        do_cycle(0, 0, 1, 32'h100);
        check_val("wait_redir_flush", 32'(last_flush), 32'd1);
        lat_min = 1; lat_max = 1;
        found = 0; vseen = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            do_cycle(0, 0, 0, 0);
            if (last_valid) vseen++;
            found = last_req;
        end
        check_val("late_data_dropped", 32'(vseen), 32'd0);
        check_val("redir_req_seen", 32'(found), 32'd1);
        check_val("redir_addr", last_addr, 32'h100);

        // Redirect in DELIVER overrides stall.
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 1, 1, 32'h200);
        check_val("deliver_redir_flush", 32'(last_flush), 32'd1);
        check_val("deliver_redir_valid_pre", 32'(last_valid), 32'd1);
        do_cycle(0, 0, 0, 0);
        check_val("deliver_redir_valid_post", 32'(last_valid), 32'd0);
        check_val("deliver_redir_req", 32'(last_req), 32'd1);
        check_val("deliver_redir_addr", last_addr, 32'h200);

        // Misaligned redirect from ISSUE.
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 1, 32'h102);
        nreq = 0; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            do_cycle(0, 0, 0, 0);
            if (last_req) nreq++;
            if (!TRAP) found = last_req;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("trap_no_req", 32'(nreq), 32'd0);
        check_val("trap_fault", 32'(last_fault), 32'd1);
        do_cycle(0, 0, 1, 32'h40);
        check_val("trap_ignores_redirect", 32'(last_req), 32'd0);
        do_cycle(1, 0, 0, 0);
        do_cycle(1, 0, 0, 0);
        check_val("trap_cleared", 32'(last_fault), 32'd0);
`else
        check_val("misalign_req_seen", 32'(found), 32'd1);
        check_val("misalign_addr", last_addr, 32'h100);
`endif

        // Randomized traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            bit          r, s, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(TRAP ? 39 : 149, 0) == 0);
            s   = ($urandom_range(2, 0) == 0);
            rd  = ($urandom_range(7, 0) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(15, 0) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
            do_cycle(r, s, rd, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage that drives the IF/ID pipeline register. Holds the PC, issues one instruction-memory read at a time, and presents each fetched word with its PC and a valid strobe. Honours stalls from the hazard unit and redirects from EX, and generates the IF/ID flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hazard stall; the inverse drives IF/ID IFIDWrite.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  read request, one-cycle pulse.
- imem_addr  out  32  read address, valid while imem_req=1.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instruction  out  32  fetched word, to IF/ID instruction.
- pc_out  out  32  PC of instruction.
- inst_valid  out  1  instruction valid, to IF/ID enable.
- flush  out  1  to IF/ID Flush; combinational, equals redirect & ~rst.

## Operation
- States: ISSUE, WAIT, DELIVER, DISCARD. At most one memory read outstanding.
- Reset:
  - state=ISSUE, pc=RESET_PC.
  - instruction=0, pc_out=0, inst_valid=0.
  - imem_req=0 and imem_addr=0 while rst=1.
- ISSUE:
  - imem_req = ~redirect; imem_addr = pc.
  - Without redirect, next state is WAIT.
- WAIT:
  - On imem_rvalid: instruction<=imem_rdata, pc_out<=pc, inst_valid<=1, next state DELIVER.
  - Without imem_rvalid: remain in WAIT.
- DELIVER:
  - If stall=0, the word is consumed at this edge: inst_valid<=0, pc<=pc+4, next state ISSUE.
  - If stall=1: hold every output and remain in DELIVER.
- DISCARD:
  - Drop the next imem_rvalid: no output update, go to ISSUE.
- Redirect (priority: rst > redirect > everything else). Every case loads pc<=redirect_pc and clears inst_valid:
  - In ISSUE: stay in ISSUE. No request is issued this cycle.
  - In WAIT, without imem_rvalid the same cycle: go to DISCARD.
  - In WAIT, with imem_rvalid the same cycle: drop the data, go to ISSUE.
  - In DISCARD, without rvalid: stay in DISCARD.
  - In DISCARD, with rvalid: go to ISSUE.
  - In DELIVER: go to ISSUE. Redirect overrides stall.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- imem_rvalid in ISSUE or DELIVER is ignored.
- The memory also receives rst and drops any in-flight response; reset mid-fetch needs no discard.

## Timing
- First imem_req is in the first cycle with rst=0.
- Minimum memory latency: rvalid one cycle after imem_req.
- Cycle t ISSUE, t+1 rvalid, t+2 inst_valid=1. With no stall, next ISSUE at t+3, giving 1 instruction per 3 cycles.
- IF/ID captures at the edge where inst_valid=1 and stall=0. This is the same edge at which pc advances.
- flush has zero latency. At the redirect edge IF/ID clears rather than captures, because inst_valid is forced low only after that edge.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - Adds output fetch_fault (1 bit), reset 0.
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1 (sticky) and enters state FAULT.
  - FAULT issues no requests, holds inst_valid=0 and ignores redirect and rvalid until rst.
  - flush still asserts.
- Undefined: no fetch_fault port. redirect_pc[1:0] is ignored and the PC loads {redirect_pc[31:2],2'b00}.

## Test plan
- Reset, then memory answers 1 cycle after each request with data = address ^ 32'hA5A5_0000, no stall. Required:
  - imem_addr sequence 0, 4, 8.
  - inst_valid pulses every 3 cycles.
  - pc_out matches each word.
- Stall held 4 cycles while in DELIVER on pc 8. Required:
  - instruction and pc_out=8 stable, inst_valid=1 throughout.
  - No imem_req during the stall.
  - Next request at 12.
- Redirect to 32'h100 while in WAIT (rvalid 3 cycles later). Required:
  - flush=1 for that cycle.
  - The late data is dropped, inst_valid stays 0.
  - Next imem_addr=32'h100.
- Redirect to 32'h200 in DELIVER together with stall=1. Required:
  - flush=1, inst_valid=0 the next cycle.
  - Next imem_addr=32'h200.
- RESET_PC=32'hFFFF_FFFC. Required: first address FFFF_FFFC, second address 0.
- Redirect to 32'h102. Required:
  - With FETCH_MISALIGN_TRAP_EN: fetch_fault=1 and no further imem_req until rst.
  - Without it: next imem_addr=32'h100.
